// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch unit owns the request side; the memory answers with ack and data.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests feeding a 2-entry
// {pc, instr} queue whose head drives the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  fetch_unit_if.master imem,
  output logic         fetch_valid_o,
  output logic [31:0]  pc_out_o,
  output logic [31:0]  IR_o,
  output logic [31:0]  next_pc_o
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] imemAddr_q, imemAddr_d;
  logic        imemReq_q;
  logic [31:0] pcMem_q [2];
  logic [31:0] instrMem_q [2];

  logic ackValid;
  logic consume;
  logic push;
  logic tail;

  assign ackValid      = imem.imem_ack & imemReq_q;
  assign fetch_valid_o = (count_q != 2'd0);
  assign consume       = fetch_valid_o & ~stall_i & ~redirect_i;
  // Only a live (non-stale) request in REQ deposits data; a redirect discards it.
  assign push          = ackValid & (state_q == REQ) & ~redirect_i;
  assign tail          = head_q ^ count_q[0];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    head_d    = head_q;
    fetchPc_d = fetchPc_q;
    if (redirect_i) begin
      count_d   = 2'd0;
      head_d    = 1'b0;
      fetchPc_d = redirect_pc_i & ~32'd3;
      if ((state_q == REQ || state_q == DRAIN) && !ackValid)
        state_d = DRAIN;
      else
        state_d = REQ;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, consume};
      if (consume)
        head_d = ~head_q;
      if (push)
        fetchPc_d = fetchPc_q + 32'd4;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     if (push && count_d == 2'd2) state_d = FULL;
        FULL:    if (count_d <= 2'd1) state_d = REQ;
        DRAIN:   if (ackValid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
    // A stale request keeps its address on the bus until memory answers it.
    imemAddr_d = (state_d == DRAIN) ? imemAddr_q : fetchPc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      fetchPc_q  <= RESET_PC;
      imemAddr_q <= RESET_PC;
      imemReq_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pcMem_q[i]    <= RESET_PC;
        instrMem_q[i] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      fetchPc_q  <= fetchPc_d;
      imemAddr_q <= imemAddr_d;
      imemReq_q  <= (state_d == REQ) || (state_d == DRAIN);
      if (push) begin
        pcMem_q[tail]    <= fetchPc_q;
        instrMem_q[tail] <= imem.imem_rdata;
      end
    end
  end

  assign imem.imem_req  = imemReq_q;
  assign imem.imem_addr = imemAddr_q;
  assign pc_out_o       = pcMem_q[head_q];
  assign IR_o           = fetch_valid_o ? instrMem_q[head_q] : 32'h0;
  assign next_pc_o      = pc_out_o + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables and corner sequences plus a randomized
// run checked against a queue-level model of the delivered instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        fetchValid;
  logic [31:0] pcOut, ir, nextPc;

  fetch_unit_if imemBus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .imem          (imemBus),
    .fetch_valid_o (fetchValid),
    .pc_out_o      (pcOut),
    .IR_o          (ir),
    .next_pc_o     (nextPc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a ^ 32'hA5A5_5A5A) + {a[7:0], a[31:8]};
  endfunction

  // Memory: fixed latency (1 = same-cycle ack), random ack, or ack forced high.
  int   latency = 1;
  logic randomMode = 1'b0;
  logic forceAck = 1'b0;
  int   waitCnt;
  logic randBit;

  assign imemBus.imem_ack = forceAck |
    (imemBus.imem_req & (randomMode ? randBit : (waitCnt >= latency - 1)));
  assign imemBus.imem_rdata = (imemBus.imem_req && imemBus.imem_ack) ?
    memFn(imemBus.imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= 0;
      randBit <= 1'b0;
    end else begin
      if (!imemBus.imem_req || imemBus.imem_ack) waitCnt <= 0;
      else waitCnt <= waitCnt + 1;
      randBit <= ($urandom % 2) == 0;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall = s;
    redirect = r;
    redirectPc = rpc;
  endtask

  // Reference model: queue of PCs owed to the pipeline, plus a redirect epoch
  // that marks any request begun before the latest redirect/reset as stale.
  logic [31:0] modelQ[$];
  int          epoch = 0;
  int          reqEpoch = -1;
  logic [31:0] expFetch = RESET_PC;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic [31:0] prevAddr = 32'h0;
  int          consumed = 0;

  task automatic modelStep();
    logic ackEff, reqStart, take;
    if (!rst_n) begin
      checkOutput("rstReq", imemBus.imem_req, 1'b0);
      checkOutput("rstValid", fetchValid, 1'b0);
      checkOutput("rstIR", ir, 32'h0);
      checkOutput("rstPc", pcOut, RESET_PC);
      checkOutput("rstNextPc", nextPc, RESET_PC + 32'd4);
      modelQ.delete();
      epoch++;
      expFetch = RESET_PC;
      prevReq = 1'b0;
      prevAck = 1'b0;
      return;
    end
    checkOutput("valid", fetchValid, modelQ.size() != 0);
    if (modelQ.size() != 0) begin
      checkOutput("pcOut", pcOut, modelQ[0]);
      checkOutput("IR", ir, memFn(modelQ[0]));
      checkOutput("nextPc", nextPc, modelQ[0] + 32'd4);
    end else begin
      checkOutput("IRempty", ir, 32'h0);
    end
    if (prevReq && !prevAck) begin
      checkOutput("reqHeld", imemBus.imem_req, 1'b1);
      checkOutput("addrHeld", imemBus.imem_addr, prevAddr);
    end
    reqStart = imemBus.imem_req && (!prevReq || prevAck);
    if (reqStart) begin
      reqEpoch = epoch;
      checkOutput("reqAddr", imemBus.imem_addr, expFetch);
    end
    ackEff = imemBus.imem_req && imemBus.imem_ack;
    take = (modelQ.size() != 0) && !stall && !redirect;
    if (redirect) begin
      modelQ.delete();
      epoch++;
      expFetch = {redirectPc[31:2], 2'b00};
    end else begin
      if (take) begin
        void'(modelQ.pop_front());
        consumed++;
      end
      if (ackEff && reqEpoch == epoch) begin
        modelQ.push_back(expFetch);
        expFetch = expFetch + 32'd4;
        checkOutput("qDepth", modelQ.size() <= 2, 1'b1);
      end
    end
    prevReq = imemBus.imem_req;
    prevAck = ackEff;
    prevAddr = imemBus.imem_addr;
  endtask

  task automatic halfCycle();
    @(negedge clk);
    modelStep();
  endtask

  task automatic toNextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    halfCycle();
    toNextCycle();
    rst_n = 1'b1;
  endtask

  task automatic expectCycle(input string tag, input logic eReq, input logic [31:0] eAddr,
                             input logic eValid, input logic [31:0] ePc);
    checkOutput({tag, ".req"}, imemBus.imem_req, eReq);
    if (eReq) checkOutput({tag, ".addr"}, imemBus.imem_addr, eAddr);
    checkOutput({tag, ".valid"}, fetchValid, eValid);
    if (eValid) begin
      checkOutput({tag, ".pc"}, pcOut, ePc);
      checkOutput({tag, ".next"}, nextPc, ePc + 32'd4);
      checkOutput({tag, ".ir"}, ir, memFn(ePc));
    end else begin
      checkOutput({tag, ".ir0"}, ir, 32'h0);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t streamVecs[13];

  initial begin
    streamVecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h000, 1'b0, 32'h000};
    streamVecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h000};
    streamVecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100};
    streamVecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h104};
    streamVecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h108};
    streamVecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h000, 1'b1, 32'h108};
    streamVecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h000, 1'b1, 32'h108};
    streamVecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h000, 1'b1, 32'h108};
    streamVecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h000, 1'b1, 32'h108};
    streamVecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h000, 1'b1, 32'h108};
    streamVecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h110, 1'b1, 32'h10C};
    streamVecs[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h114, 1'b1, 32'h110};
    streamVecs[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h118, 1'b1, 32'h114};

    // Streaming with ack tied high, then a 5-cycle stall fill and release.
    forceAck = 1'b1;
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(streamVecs[i].stall, streamVecs[i].redirect, streamVecs[i].rpc);
      halfCycle();
      expectCycle($sformatf("stream%0d", i), streamVecs[i].expReq, streamVecs[i].expAddr,
                  streamVecs[i].expValid, streamVecs[i].expPc);
      toNextCycle();
    end

    // Redirect to 0x2000 while a latency-3 request to 0x40 is outstanding.
    forceAck = 1'b0;
    latency = 3;
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h40);     halfCycle(); expectCycle("drain0", 1'b0, 32'h0, 1'b0, 32'h0); toNextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);      halfCycle(); expectCycle("drain1", 1'b1, 32'h40, 1'b0, 32'h0); toNextCycle();
    applyStimulus(1'b0, 1'b1, 32'h2000);   halfCycle(); expectCycle("drain2", 1'b1, 32'h40, 1'b0, 32'h0); toNextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);      halfCycle(); expectCycle("drain3", 1'b1, 32'h40, 1'b0, 32'h0); toNextCycle();
    for (int i = 4; i < 7; i++) begin
      halfCycle(); expectCycle($sformatf("drain%0d", i), 1'b1, 32'h2000, 1'b0, 32'h0); toNextCycle();
    end
    halfCycle(); expectCycle("drain7", 1'b1, 32'h2004, 1'b1, 32'h2000); toNextCycle();

    // Redirect coinciding with an ack while stalled: the ack data is dropped.
    forceAck = 1'b1;
    latency = 1;
    doReset();
    for (int i = 0; i < 3; i++) begin
      halfCycle(); toNextCycle();
    end
    applyStimulus(1'b1, 1'b1, 32'h3000);   halfCycle(); expectCycle("rdAck3", 1'b1, 32'h108, 1'b1, 32'h104); toNextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);      halfCycle(); expectCycle("rdAck4", 1'b1, 32'h3000, 1'b0, 32'h0); toNextCycle();
    halfCycle(); expectCycle("rdAck5", 1'b1, 32'h3004, 1'b1, 32'h3000); toNextCycle();

    // Wrap of the fetch address past the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE); halfCycle(); toNextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    halfCycle(); expectCycle("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); toNextCycle();
    halfCycle(); expectCycle("wrap1", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC); toNextCycle();
    halfCycle(); expectCycle("wrap2", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000); toNextCycle();

    // Asynchronous reset while draining, with a stray ack pulse afterwards.
    forceAck = 1'b0;
    latency = 3;
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h40);  halfCycle(); toNextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);   halfCycle(); toNextCycle();
    applyStimulus(1'b0, 1'b1, 32'h80);  halfCycle(); toNextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncReq", imemBus.imem_req, 1'b0);
    checkOutput("asyncValid", fetchValid, 1'b0);
    checkOutput("asyncIR", ir, 32'h0);
    checkOutput("asyncPc", pcOut, RESET_PC);
    checkOutput("asyncNext", nextPc, RESET_PC + 32'd4);
    forceAck = 1'b1;
    halfCycle();
    toNextCycle();
    rst_n = 1'b1;
    halfCycle(); expectCycle("arst0", 1'b0, 32'h0, 1'b0, 32'h0); toNextCycle();
    forceAck = 1'b0;
    halfCycle(); expectCycle("arst1", 1'b1, RESET_PC, 1'b0, 32'h0); toNextCycle();
    for (int i = 2; i < 4; i++) begin
      halfCycle(); toNextCycle();
    end
    halfCycle(); expectCycle("arst4", 1'b1, RESET_PC + 32'd4, 1'b1, RESET_PC); toNextCycle();

    // Randomized stall/redirect/ack traffic checked only by the model.
    randomMode = 1'b1;
    doReset();
    consumed = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_n = 1'b0;
        halfCycle();
        toNextCycle();
        rst_n = 1'b1;
      end
      applyStimulus(($urandom % 10) < 3, ($urandom % 25) == 0,
                    (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom);
      halfCycle();
      toNextCycle();
    end
    checkOutput("progress", consumed > 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
